// File: rtl/cache_fill_fsm.sv
// Miss-handling controller: on a cache miss, fetches the aligned block from main memory
// one word per request and streams returned words into the data array, writing the tag on the last.
module cache_fill_fsm #(
  parameter int ADDR_WIDTH      = 16,
  parameter int WORDS_PER_BLOCK = 8,
  parameter int OFF_W           = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  miss_detected,
  input  logic [ADDR_WIDTH-1:0] miss_address,
  output logic                  fsm_busy,
  output logic                  memory_enable,
  output logic [ADDR_WIDTH-1:0] memory_address,
  input  logic                  memory_data_valid,
  input  logic [15:0]           memory_data_in,
  output logic                  write_data_array,
  output logic                  write_tag_array,
  output logic [OFF_W-1:0]      cache_word_offset,
  output logic [15:0]           cache_data_out
);

  localparam logic [ADDR_WIDTH-1:0] BLK_MASK = ADDR_WIDTH'(2 * WORDS_PER_BLOCK - 1);
  localparam logic [OFF_W-1:0]      LAST_OFF = OFF_W'(WORDS_PER_BLOCK - 1);

  typedef enum logic {IDLE, FILL} state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] base;
  logic [OFF_W-1:0]      req_cnt;
  logic [OFF_W-1:0]      rcv_cnt;
  logic                  req_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      base     <= '0;
      req_cnt  <= '0;
      rcv_cnt  <= '0;
      req_done <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (miss_detected) begin
            base     <= miss_address & ~BLK_MASK;
            req_cnt  <= '0;
            rcv_cnt  <= '0;
            req_done <= 1'b0;
          end
        end
        FILL: begin
          // Both counters wrap to 0 at block end, leaving them ready for the next fill.
          if (!req_done) begin
            req_cnt <= req_cnt + 1'b1;
            if (req_cnt == LAST_OFF) req_done <= 1'b1;
          end
          if (memory_data_valid) rcv_cnt <= rcv_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt         = state;
    fsm_busy          = 1'b0;
    memory_enable     = 1'b0;
    memory_address    = '0;
    write_data_array  = 1'b0;
    write_tag_array   = 1'b0;
    cache_word_offset = '0;
    cache_data_out    = '0;
    case (state)
      IDLE: begin
        if (miss_detected) state_nxt = FILL;
      end
      FILL: begin
        fsm_busy          = 1'b1;
        memory_enable     = !req_done;
        // base is block-aligned, so the offset never carries out of the block.
        memory_address    = base + ADDR_WIDTH'({req_cnt, 1'b0});
        write_data_array  = memory_data_valid;
        cache_word_offset = rcv_cnt;
        cache_data_out    = memory_data_in;
        if (memory_data_valid && rcv_cnt == LAST_OFF) begin
          write_tag_array = 1'b1;
          state_nxt       = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Scoreboard bench for cache_fill_fsm: expected requests/writes are queued at stimulus time
// and a negedge monitor pops and compares them; a behavioural memory returns words in order.
module tb_cache_fill_fsm;

  localparam logic [15:0] KEY = 16'h5A5A;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        miss_detected = 1'b0;
  logic [15:0] miss_address = '0;
  logic        fsm_busy;
  logic        memory_enable;
  logic [15:0] memory_address;
  logic        memory_data_valid;
  logic [15:0] memory_data_in;
  logic        write_data_array;
  logic        write_tag_array;
  logic [2:0]  cache_word_offset;
  logic [15:0] cache_data_out;

  logic        mem_valid = 1'b0;
  logic        spur_valid = 1'b0;
  logic [15:0] mem_data = '0;

  assign memory_data_valid = mem_valid | spur_valid;
  assign memory_data_in    = mem_valid ? mem_data : 16'hDEAD;

  cache_fill_fsm #(.ADDR_WIDTH(16), .WORDS_PER_BLOCK(8), .OFF_W(3)) dut (
    .clk(clk), .rst(rst),
    .miss_detected(miss_detected), .miss_address(miss_address),
    .fsm_busy(fsm_busy), .memory_enable(memory_enable), .memory_address(memory_address),
    .memory_data_valid(memory_data_valid), .memory_data_in(memory_data_in),
    .write_data_array(write_data_array), .write_tag_array(write_tag_array),
    .cache_word_offset(cache_word_offset), .cache_data_out(cache_data_out)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [2:0] off; logic [15:0] data; logic tag; } wr_t;
  typedef struct packed { logic [15:0] addr; logic [31:0] due; } pend_t;

  logic [15:0] exp_req[$];
  wr_t         exp_wr[$];
  pend_t       pending[$];

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          last_due = 0;
  int          tag_cyc = 0;
  int          wr_cnt = 0;
  int          lat_min = 4;
  int          lat_max = 4;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory: returns one word per cycle, in request order, no earlier than its latency.
  always @(posedge clk) begin
    #1;
    if (rst) begin
      mem_valid = 1'b0;
      pending.delete();
    end else if (pending.size() > 0 && int'(pending[0].due) <= cyc) begin
      mem_valid = 1'b1;
      mem_data  = pending[0].addr ^ KEY;
      void'(pending.pop_front());
    end else begin
      mem_valid = 1'b0;
    end
  end

  // Monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (memory_enable) begin
        int lat;
        int due;
        lat = (lat_min == lat_max) ? lat_min : int'($urandom_range(lat_max, lat_min));
        due = cyc + lat;
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        pending.push_back('{addr: memory_address, due: 32'(due)});
        if (exp_req.size() == 0) chk("unexpected_req", {16'h0, memory_address}, 32'hFFFFFFFF);
        else chk("req_addr", {16'h0, memory_address}, {16'h0, exp_req.pop_front()});
      end
      if (write_data_array) begin
        wr_cnt++;
        if (write_tag_array) tag_cyc = cyc;
        if (exp_wr.size() == 0) chk("unexpected_write", {29'h0, cache_word_offset}, 32'hFFFFFFFF);
        else begin
          wr_t e;
          e = exp_wr.pop_front();
          chk("wr_offset", {29'h0, cache_word_offset}, {29'h0, e.off});
          chk("wr_data", {16'h0, cache_data_out}, {16'h0, e.data});
          chk("wr_tag", {31'h0, write_tag_array}, {31'h0, e.tag});
        end
      end else if (write_tag_array) begin
        chk("tag_without_data", {31'h0, write_tag_array}, 32'h0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push_expect(input logic [15:0] base);
    for (int i = 0; i < 8; i++) begin
      logic [15:0] a;
      a = base + 16'(2 * i);
      exp_req.push_back(a);
      exp_wr.push_back('{off: 3'(i), data: a ^ KEY, tag: (i == 7)});
    end
  endtask

  task automatic check_outputs_zero(input string name);
    chk({name, "_busy"}, {31'h0, fsm_busy}, 32'h0);
    chk({name, "_men"}, {31'h0, memory_enable}, 32'h0);
    chk({name, "_maddr"}, {16'h0, memory_address}, 32'h0);
    chk({name, "_wda"}, {31'h0, write_data_array}, 32'h0);
    chk({name, "_wta"}, {31'h0, write_tag_array}, 32'h0);
    chk({name, "_off"}, {29'h0, cache_word_offset}, 32'h0);
    chk({name, "_dout"}, {16'h0, cache_data_out}, 32'h0);
  endtask

  // Counts busy cycles starting from the current one until busy drops (bounded).
  task automatic wait_busy_drop(output int n);
    n = 0;
    while (fsm_busy && n < 300) begin
      n++;
      tick();
    end
    if (fsm_busy) chk("busy_timeout", 32'd1, 32'd0);
  endtask

  task automatic check_fill_end(input string name);
    chk({name, "_drop_after_tag"}, 32'(cyc), 32'(tag_cyc + 1));
    chk({name, "_reqs_left"}, 32'(exp_req.size()), 32'd0);
    chk({name, "_wrs_left"}, 32'(exp_wr.size()), 32'd0);
  endtask

  task automatic start_fill(input logic [15:0] addr, input logic [15:0] base);
    push_expect(base);
    miss_address  = addr;
    miss_detected = 1'b1;
    tick();
    miss_detected = 1'b0;
    chk("busy_first_cycle", {31'h0, fsm_busy}, 32'd1);
  endtask

  initial begin
    int n;
    int w0;
    #3;
    check_outputs_zero("reset");
    tick();
    tick();
    rst = 1'b0;
    tick();
    check_outputs_zero("idle");

    // 1: basic fill, fixed 4-cycle memory
    start_fill(16'h1236, 16'h1230);
    wait_busy_drop(n);
    chk("t1_busy_cycles", 32'(n), 32'd12);
    check_fill_end("t1");
    tick();

    // 2: top block, no wrap past 0xFFFE
    start_fill(16'hFFFF, 16'hFFF0);
    wait_busy_drop(n);
    chk("t2_busy_cycles", 32'(n), 32'd12);
    check_fill_end("t2");
    tick();

    // 3: irregular return gaps
    lat_min = 4;
    lat_max = 10;
    start_fill(16'hA5C8, 16'hA5C0);
    wait_busy_drop(n);
    check_fill_end("t3");
    lat_min = 4;
    lat_max = 4;
    tick();

    // 4a: spurious valid while idle
    spur_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t4_idle_wda", {31'h0, write_data_array}, 32'h0);
      chk("t4_idle_wta", {31'h0, write_tag_array}, 32'h0);
    end
    spur_valid = 1'b0;
    tick();

    // 4b: miss toggled during fill
    start_fill(16'h0A12, 16'h0A10);
    for (int i = 0; i < 5; i++) begin
      miss_address  = 16'hBEEF;
      miss_detected = ~miss_detected;
      tick();
    end
    miss_detected = 1'b0;
    wait_busy_drop(n);
    check_fill_end("t4");
    tick();
    chk("t4_no_extra_req", {31'h0, memory_enable}, 32'h0);
    tick();

    // 5: async reset mid-fill
    w0 = wr_cnt;
    start_fill(16'h1000, 16'h1000);
    n = 0;
    while (wr_cnt < w0 + 3 && n < 100) begin
      n++;
      tick();
    end
    chk("t5_three_writes", 32'(wr_cnt - w0), 32'd3);
    #1 rst = 1'b1;
    #1;
    check_outputs_zero("t5_rst");
    exp_req.delete();
    exp_wr.delete();
    pending.delete();
    last_due = 0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("t5_idle_busy", {31'h0, fsm_busy}, 32'h0);
    chk("t5_idle_men", {31'h0, memory_enable}, 32'h0);
    start_fill(16'h0040, 16'h0040);
    wait_busy_drop(n);
    chk("t5_busy_cycles", 32'(n), 32'd12);
    check_fill_end("t5");
    tick();

    // 6: back-to-back with miss held high
    push_expect(16'h2220);
    push_expect(16'h3450);
    miss_address  = 16'h2222;
    miss_detected = 1'b1;
    tick();
    miss_address = 16'h3456;
    wait_busy_drop(n);
    chk("t6_fill1_cycles", 32'(n), 32'd12);
    chk("t6_gap_idle", {31'h0, fsm_busy}, 32'h0);
    tick();
    chk("t6_fill2_started", {31'h0, fsm_busy}, 32'd1);
    miss_detected = 1'b0;
    wait_busy_drop(n);
    chk("t6_fill2_cycles", 32'(n), 32'd12);
    check_fill_end("t6");
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
